// File: rtl/code_sequencer.sv
// Debounced push-button up/down sequencer driving a 5-bit code (c1 = MSB .. c5 = LSB).
// Define CODE_SEQUENCER_AUTO_STEP_EN to add a prescaler that also steps the code every AUTO_DIV cycles.
module code_sequencer #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int AUTO_DIV        = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_step,
   input  logic up_down,
   input  logic clear,
   input  logic hold,
   output logic c1,
   output logic c2,
   output logic c3,
   output logic c4,
   output logic c5,
   output logic changed
);

   // state        | meaning
   // IDLE         | button released and accepted as released
   // PRESS_WAIT   | button seen high, counting consecutive high samples
   // PRESSED      | press accepted, one step request issued on entry
   // RELEASE_WAIT | button seen low, counting consecutive low samples
   typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] DB_TC = CW'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1 || AUTO_DIV < 1) begin : g_param_check
      $error("code_sequencer: DEBOUNCE_CYCLES and AUTO_DIV must be at least 1");
   end

   logic [1:0]    rst_sync_q;
   logic          run;
   logic [1:0]    btn_sync_q;
   logic          btn_s;
   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic          step_q;
   logic          step_req;
   logic [4:0]    code_q;
   logic [4:0]    code_d;
   logic          changed_q;

   // Reset asserts immediately but is released only after two clk edges;
   // every other register is held until run goes high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end

   assign run = rst_sync_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   btn_sync_q <= 2'b00;
      else if (run) btn_sync_q <= {btn_sync_q[0], btn_step};
   end

   assign btn_s = btn_sync_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         step_q  <= 1'b0;
      end else if (run) begin
         step_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (btn_s) begin
                  state_q <= PRESS_WAIT;
                  cnt_q   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!btn_s) begin
                  state_q <= IDLE;
               end else if (cnt_q == DB_TC) begin
                  state_q <= PRESSED;
                  step_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            PRESSED: begin
               if (!btn_s) begin
                  state_q <= RELEASE_WAIT;
                  cnt_q   <= '0;
               end
            end
            RELEASE_WAIT: begin
               if (btn_s) begin
                  state_q <= PRESSED;
               end else if (cnt_q == DB_TC) begin
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef CODE_SEQUENCER_AUTO_STEP_EN
   localparam int PRE_W = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(AUTO_DIV - 1);

   logic [PRE_W-1:0] pre_q;
   logic             auto_tick;

   assign auto_tick = (pre_q == PRE_TC) && !hold;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
      end else if (run) begin
         if (clear)          pre_q <= '0;
         else if (auto_tick) pre_q <= '0;
         else if (!hold)     pre_q <= pre_q + 1'b1;
      end
   end

   // A coincident button and auto step collapse into a single step.
   assign step_req = step_q | auto_tick;
`else
   assign step_req = step_q;
`endif

   always_comb begin
      code_d = code_q;
      if (clear)                  code_d = 5'd0;
      else if (!hold && step_req) code_d = up_down ? code_q + 5'd1 : code_q - 5'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_q    <= 5'd0;
         changed_q <= 1'b0;
      end else if (run) begin
         code_q    <= code_d;
         changed_q <= (code_d != code_q);
      end
   end

   assign {c1, c2, c3, c4, c5} = code_q;
   assign changed              = changed_q;

endmodule

// File: tb/tb_code_sequencer.sv
// Bench for code_sequencer: directed scenarios plus randomized button/clear/hold traffic
// checked every cycle against a run-length debounce model.
module tb_code_sequencer;

   localparam int DEB = 4;
   localparam int AD  = 8;

   logic clk      = 1'b0;
   logic rst_n    = 1'b0;
   logic btn_step = 1'b0;
   logic up_down  = 1'b1;
   logic clear    = 1'b0;
   logic hold     = 1'b0;
   logic c1, c2, c3, c4, c5, changed;
   logic [4:0] code;

   int n_chk  = 0;
   int n_fail = 0;
   int pulses = 0;
   int n      = 0;

   code_sequencer #(.DEBOUNCE_CYCLES(DEB), .AUTO_DIV(AD)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_step (btn_step),
      .up_down  (up_down),
      .clear    (clear),
      .hold     (hold),
      .c1       (c1),
      .c2       (c2),
      .c3       (c3),
      .c4       (c4),
      .c5       (c5),
      .changed  (changed)
   );

   always #5 clk = ~clk;

   assign code = {c1, c2, c3, c4, c5};

   // Reference model: the button is seen two active edges late; the accepted level
   // flips once DEB+1 consecutive samples disagree with it, and a flip to 1 steps
   // the code on the following edge.
   int m_code  = 0;
   int m_edges = 0;
   int m_run   = 0;
   int m_pre   = 0;
   int m_nxt   = 0;
   bit m_acc   = 0;
   bit m_step  = 0;
   bit m_tick  = 0;
   bit m_s     = 0;
   bit m_changed = 0;
   bit m_pipe0 = 0;
   bit m_pipe1 = 0;

   always @(posedge clk or negedge rst_n) begin : model
      if (!rst_n) begin
         m_code = 0; m_changed = 0; m_edges = 0; m_run = 0; m_pre = 0;
         m_acc = 0; m_step = 0; m_pipe0 = 0; m_pipe1 = 0;
      end else begin
         m_edges++;
         if (m_edges >= 3) begin
            m_s     = m_pipe1;
            m_pipe1 = m_pipe0;
            m_pipe0 = btn_step;
            m_tick  = 0;
`ifdef CODE_SEQUENCER_AUTO_STEP_EN
            if (clear) m_pre = 0;
            else if (!hold) begin
               if (m_pre == AD - 1) begin m_pre = 0; m_tick = 1; end
               else m_pre++;
            end
`endif
            m_nxt = m_code;
            if (clear) m_nxt = 0;
            else if (!hold && (m_step || m_tick)) m_nxt = up_down ? (m_code + 1) % 32 : (m_code + 31) % 32;
            m_changed = (m_nxt != m_code);
            m_code    = m_nxt;
            m_step    = 0;
            if (m_s == m_acc) m_run = 0;
            else begin
               m_run++;
               if (m_run == DEB + 1) begin
                  m_acc  = m_s;
                  m_run  = 0;
                  m_step = m_s;
               end
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step_cyc();
      @(negedge clk);
      check("code", 32'(code), 32'(m_code));
      check("changed", 32'(changed), 32'(m_changed));
      if (changed === 1'b1) pulses++;
   endtask

   task automatic run_cyc(input int cycles);
      repeat (cycles) step_cyc();
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_code", 32'(code), 32'd0);
      check("rst_async_changed", 32'(changed), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic press(input int len, input int gap);
      btn_step = 1'b1;
      run_cyc(len);
      btn_step = 1'b0;
      run_cyc(gap);
   endtask

   // Counts cycles until changed is observed; returns limit+1 if it never appears.
   task automatic wait_changed(input int limit, output int cycles);
      cycles = 0;
      for (int i = 0; i < limit; i++) begin
         step_cyc();
         cycles++;
         if (changed === 1'b1) return;
      end
      cycles = limit + 1;
   endtask

   initial begin
      do_reset();
      run_cyc(3);
      check("reset_code", 32'(code), 32'd0);
      check("reset_changed", 32'(changed), 32'd0);

`ifndef CODE_SEQUENCER_AUTO_STEP_EN
      // clean 10-cycle press, then keep holding: one increment only
      pulses = 0;
      up_down = 1'b1;
      btn_step = 1'b1;
      run_cyc(30);
      btn_step = 1'b0;
      run_cyc(10);
      check("clean_press_code", 32'(code), 32'd1);
      check("clean_press_pulses", 32'(pulses), 32'd1);

      // bounce 1,0,1,0 then stable: 2 sync + 1 detect + 4 stable + 1 register = 8
      pulses = 0;
      btn_step = 1'b1; step_cyc();
      btn_step = 1'b0; step_cyc();
      btn_step = 1'b1; step_cyc();
      btn_step = 1'b0; step_cyc();
      btn_step = 1'b1;
      wait_changed(20, n);
      check("bounce_latency", 32'(n), 32'd8);
      run_cyc(10);
      btn_step = 1'b0;
      run_cyc(10);
      check("bounce_code", 32'(code), 32'd2);
      check("bounce_pulses", 32'(pulses), 32'd1);

      // wrap-around both ways
      clear = 1'b1; step_cyc(); clear = 1'b0;
      pulses = 0;
      up_down = 1'b0;
      press(8, 10);
      check("wrap_down_code", 32'(code), 32'd31);
      check("wrap_down_pulses", 32'(pulses), 32'd1);
      pulses = 0;
      up_down = 1'b1;
      press(8, 10);
      check("wrap_up_code", 32'(code), 32'd0);
      check("wrap_up_pulses", 32'(pulses), 32'd1);

      // clear coinciding with a step request at code 7
      repeat (7) press(8, 10);
      check("count_to_7", 32'(code), 32'd7);
      btn_step = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step_cyc();
         if (m_step) break;
      end
      check("step_req_seen", 32'(m_step), 32'd1);
      clear = 1'b1;
      step_cyc();
      clear = 1'b0;
      check("clear_vs_step_code", 32'(code), 32'd0);
      check("clear_vs_step_changed", 32'(changed), 32'd1);
      btn_step = 1'b0;
      run_cyc(12);
      clear = 1'b1;
      step_cyc();
      clear = 1'b0;
      check("clear_at_zero_changed", 32'(changed), 32'd0);

      // hold discards an accepted press, no late step after hold drops
      press(8, 10);
      pulses = 0;
      hold = 1'b1;
      press(8, 10);
      hold = 1'b0;
      run_cyc(20);
      check("hold_code", 32'(code), 32'd1);
      check("hold_pulses", 32'(pulses), 32'd0);

      // reset mid-PRESS_WAIT; still-held button needs the full debounce afterwards
      btn_step = 1'b1;
      run_cyc(4);
      do_reset();
      wait_changed(30, n);
      check("rst_full_debounce", 32'(n), 32'd10);
      check("rst_press_code", 32'(code), 32'd1);
      btn_step = 1'b0;
      run_cyc(12);
`else
      // auto-step: first step once the prescaler wraps, then every AD cycles
      do_reset();
      wait_changed(30, n);
      check("auto_first", 32'(n), 32'd10);
      for (int k = 0; k < 3; k++) begin
         wait_changed(20, n);
         check("auto_period", 32'(n), 32'(AD));
      end
      pulses = 0;
      hold = 1'b1;
      run_cyc(20);
      hold = 1'b0;
      check("auto_hold_pulses", 32'(pulses), 32'd0);
`endif

      // randomized traffic against the model
      for (int seg = 0; seg < 300; seg++) begin
         int len;
         if ($urandom_range(0, 39) == 0) do_reset();
         btn_step = 1'($urandom_range(0, 1));
         up_down  = 1'($urandom_range(0, 1));
         hold     = ($urandom_range(0, 5) == 0);
         len      = int'($urandom_range(1, 14));
         for (int c = 0; c < len; c++) begin
            clear = ($urandom_range(0, 11) == 0);
            step_cyc();
         end
         clear = 1'b0;
      end
      hold = 1'b0;
      btn_step = 1'b0;
      run_cyc(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/code_sequencer.md
CODE_SEQUENCER -- requirements
Module: code_sequencer

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized cycles needed to accept a button level change.
REQ-002 SHALL provide parameter AUTO_DIV, default 1000000: clock cycles between auto-steps (used only when AUTO_STEP_EN is defined).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port btn_step  input  1  raw, unsynchronized, bouncing push-button; high = pressed.
REQ-006 SHALL have port up_down  input  1  step direction; 1 = increment, 0 = decrement; synchronous level.
REQ-007 SHALL have port clear  input  1  synchronous clear of the code to 0.
REQ-008 SHALL have port hold  input  1  freezes the code while high.
REQ-009 SHALL have ports c1, c2, c3, c4, c5  output  1 each  registered 5-bit code, c1 = MSB, c5 = LSB; drives the 7-segment decoder inputs directly.
REQ-010 SHALL have port changed  output  1  one-cycle pulse in the cycle after the code register takes a new value.

Function
REQ-011 SHALL pass btn_step through a two-flop synchronizer before any other use.
REQ-012 SHALL run a debounce FSM with states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-013 IDLE -> PRESS_WAIT when the synchronized button is 1; the stability counter is cleared.
REQ-014 PRESS_WAIT -> IDLE if the synchronized button returns to 0 before DEBOUNCE_CYCLES; -> PRESSED after DEBOUNCE_CYCLES consecutive 1s, issuing a single-cycle internal step request on entry.
REQ-015 PRESSED -> RELEASE_WAIT when the synchronized button is 0; RELEASE_WAIT -> PRESSED on any 1; -> IDLE after DEBOUNCE_CYCLES consecutive 0s.
REQ-016 SHALL issue exactly one step request per accepted press, regardless of press duration.
REQ-017 On a step request with hold=0 and clear=0, SHALL update the code on the next rising edge: +1 mod 32 if up_down=1, -1 mod 32 if up_down=0.
REQ-018 Wrap-around: 31 + 1 SHALL give 0, and 0 - 1 SHALL give 31; there is no saturation.
REQ-019 clear=1 SHALL load 0 on the next edge, overriding hold and any coincident step request (priority: clear > hold > step).
REQ-020 A step request arriving while hold=1 SHALL be discarded, not queued.
REQ-021 changed SHALL pulse only when the new code differs from the old one; clearing an already-zero code gives no pulse.
REQ-022 Latency: FSM entry to PRESSED at edge N -> code updated at edge N+1 -> changed high for cycle N+1 only.
REQ-023 The debounce FSM SHALL keep running while hold or clear is high.

Reset
REQ-024 While rst_n=0, SHALL immediately force c1..c5 = 0, changed = 0, FSM = IDLE, synchronizer flops = 0, and all counters = 0, independent of clk.
REQ-025 Reset asserted mid-press SHALL discard the press; after release of rst_n, a still-held button SHALL need the full DEBOUNCE_CYCLES to be accepted.
REQ-026 rst_n deassertion SHALL be synchronized to clk internally; the first state change SHALL occur no earlier than the second rising edge after deassertion.

Configuration
REQ-027 Macro CODE_SEQUENCER_AUTO_STEP_EN: when defined, a prescaler counting 0..AUTO_DIV-1 SHALL generate a step request at each terminal count while hold=0, OR-ed with button steps; a coincident auto and button step in the same cycle SHALL count as a single step.
REQ-028 With CODE_SEQUENCER_AUTO_STEP_EN defined, the prescaler SHALL restart from 0 on clear or reset and SHALL freeze while hold=1.
REQ-029 Without the macro, no prescaler logic SHALL exist; AUTO_DIV is ignored, and only button presses step the code.

Verification (DEBOUNCE_CYCLES=4, AUTO_DIV=8 in simulation)
REQ-030 Reset, then a clean press of 10 cycles with up_down=1 -> code 00001, one changed pulse, no further change while the button is held.
REQ-031 Bounce pattern 1,0,1,0 of 1 cycle each, then stable 1 -> exactly one increment, accepted 4 cycles after the stable level.
REQ-032 Code 31 with a press and up_down=1 -> code 0; code 0 with a press and up_down=0 -> code 31; changed pulses once each time.
REQ-033 clear=1 coinciding with a step request at code 7 -> code 0, no increment; clear at code 0 -> no changed pulse.
REQ-034 hold=1 during an accepted press -> code unchanged; dropping hold afterwards gives no late step.
REQ-035 rst_n pulsed low mid-PRESS_WAIT -> outputs 0 asynchronously; with AUTO_STEP_EN, hold=0 and no button -> code increments every 8 cycles.
